// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receive peripheral: its bus window, register offsets,
// receiver states and the baud divisor floor.
package uart_rx_periph_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] UART_RX_ADDR_START = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] UART_RX_ADDR_END   = 32'h0000_020F;

    localparam logic [ADDR_W-1:0] REG_DATA   = 32'h0;
    localparam logic [ADDR_W-1:0] REG_STATUS = 32'h4;
    localparam logic [ADDR_W-1:0] REG_BAUD   = 32'h8;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 32'hC;

    localparam logic [15:0] BAUD_MIN = 16'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    function automatic logic [15:0] clamp_baud(input logic [15:0] b);
        return (b < BAUD_MIN) ? BAUD_MIN : b;
    endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// Memory-mapped bus port of the UART receive peripheral.
interface uart_rx_periph_if;
    import uart_rx_periph_pkg::*;

    logic [ADDR_W-1:0] uart_r_addr_i;
    logic [ADDR_W-1:0] uart_w_addr_i;
    logic [DATA_W-1:0] uart_data_i;
    logic              uart_r_enable_i;
    logic              uart_w_enable_i;
    logic [DATA_W-1:0] uart_data_o;

    modport master (
        output uart_r_addr_i, uart_w_addr_i, uart_data_i, uart_r_enable_i, uart_w_enable_i,
        input  uart_data_o
    );

    modport slave (
        input  uart_r_addr_i, uart_w_addr_i, uart_data_i, uart_r_enable_i, uart_w_enable_i,
        output uart_data_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; head is visible combinationally, pop on empty and
// push on full (without a simultaneous pop) are ignored.
module uart_rx_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [7:0]     data_i,
    output logic [7:0]     data_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_periph.sv
// UART receiver (8N1, LSB first) with a receive FIFO and a small register file
// for data, status, baud divisor and interrupt enable.
module uart_rx_periph
    import uart_rx_periph_pkg::*;
#(
    parameter int CLK_DIV    = 87,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_rx_periph_if.slave     bus,
    input  logic                rx,
    output logic                uart_irq_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_e         state_q, state_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0]       baud_q, div_q, cnt_q, baud_eff;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              irq_en_q, overrun_q, frame_err_q;
    logic [DATA_W-1:0] rdata_q, rd_val;
    logic              cnt_zero, load_half, load_full, shift_en, push_byte, set_frame_err;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_head, status_byte;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] r_off, w_off;
    logic              r_hit, w_hit, w_status, set_overrun;
    logic              unused_wdata;

    assign cnt_zero = (cnt_q == 16'd0);
    assign baud_eff = clamp_baud(baud_q);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load_half     = 1'b0;
        load_full     = 1'b0;
        shift_en      = 1'b0;
        push_byte     = 1'b0;
        set_frame_err = 1'b0;
        unique case (state_q)
            ST_IDLE: if (rx_prev_q && !rx_s2_q) begin
                state_d   = ST_START;
                load_half = 1'b1;
            end
            ST_START: if (cnt_zero) begin
                if (!rx_s2_q) begin
                    state_d   = ST_DATA;
                    load_full = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: if (cnt_zero) begin
                shift_en  = 1'b1;
                load_full = 1'b1;
                if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: if (cnt_zero) begin
                state_d = ST_IDLE;
                if (rx_s2_q) push_byte     = 1'b1;
                else         set_frame_err = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The divisor is latched on start entry so a BAUD write never disturbs a frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= clamp_baud(16'(CLK_DIV));
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (load_half) begin
                div_q     <= baud_eff;
                cnt_q     <= (baud_eff >> 1) - 16'd1;
                bit_idx_q <= '0;
            end else if (load_full) begin
                cnt_q <= div_q - 16'd1;
            end else if (!cnt_zero) begin
                cnt_q <= cnt_q - 16'd1;
            end
            if (shift_en) begin
                shift_q   <= {rx_s2_q, shift_q[7:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_byte),
        .pop_i   (fifo_pop),
        .data_i  (shift_q),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign r_off    = bus.uart_r_addr_i - UART_RX_ADDR_START;
    assign w_off    = bus.uart_w_addr_i - UART_RX_ADDR_START;
    assign r_hit    = bus.uart_r_enable_i && (bus.uart_r_addr_i >= UART_RX_ADDR_START)
                      && (bus.uart_r_addr_i <= UART_RX_ADDR_END);
    assign w_hit    = bus.uart_w_enable_i && (bus.uart_w_addr_i >= UART_RX_ADDR_START)
                      && (bus.uart_w_addr_i <= UART_RX_ADDR_END);
    assign w_status = w_hit && (w_off == REG_STATUS);
    assign fifo_pop = r_hit && (r_off == REG_DATA);
    // Full implies non-empty, so any same-cycle pop makes room for the new byte.
    assign set_overrun = push_byte && fifo_full && !fifo_pop;
    assign status_byte = {4'(fifo_count), frame_err_q, overrun_q, fifo_full, !fifo_empty};
    assign unused_wdata = ^bus.uart_data_i[31:16];

    always_comb begin
        rd_val = '0;
        case (r_off)
            REG_DATA:   rd_val = fifo_empty ? '0 : {24'b0, fifo_head};
            REG_STATUS: rd_val = {24'b0, status_byte};
            REG_BAUD:   rd_val = {16'b0, baud_q};
            REG_CTRL:   rd_val = {31'b0, irq_en_q};
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q      <= 16'(CLK_DIV);
            irq_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rdata_q <= r_hit ? rd_val : '0;
            if (w_hit && (w_off == REG_BAUD)) baud_q   <= bus.uart_data_i[15:0];
            if (w_hit && (w_off == REG_CTRL)) irq_en_q <= bus.uart_data_i[0];
            // A new event wins over a same-cycle clear so it is never lost.
            if (set_overrun)                          overrun_q <= 1'b1;
            else if (w_status && bus.uart_data_i[2])  overrun_q <= 1'b0;
            if (set_frame_err)                        frame_err_q <= 1'b1;
            else if (w_status && bus.uart_data_i[3])  frame_err_q <= 1'b0;
        end
    end

    assign bus.uart_data_o = rdata_q;
    assign uart_irq_o      = irq_en_q && !fifo_empty;

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: serial frames on rx, register accesses over the bus.
module tb_uart_rx_periph;
    import uart_rx_periph_pkg::*;

    localparam logic [31:0] A_DATA   = UART_RX_ADDR_START + REG_DATA;
    localparam logic [31:0] A_STATUS = UART_RX_ADDR_START + REG_STATUS;
    localparam logic [31:0] A_BAUD   = UART_RX_ADDR_START + REG_BAUD;
    localparam logic [31:0] A_CTRL   = UART_RX_ADDR_START + REG_CTRL;
    // Edges from start-bit drive to the stop-bit sample at BAUD 87: 2 sync + 1 detect + 43 + 9*87.
    localparam int STOP_EDGE = 829;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic irq;
    logic [31:0] d;
    int n_assert = 0;
    int n_fail = 0;
    int bit_cycles = 87;

    uart_rx_periph_if bus ();

    uart_rx_periph #(.CLK_DIV(87), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rx         (rx),
        .uart_irq_o (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.uart_r_addr_i   = addr;
        bus.uart_r_enable_i = 1'b1;
        @(negedge clk);
        bus.uart_r_enable_i = 1'b0;
        data = bus.uart_data_o;
        $display("read  addr=0x%08h data=0x%08h", addr, data);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        chk(tag, v, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.uart_w_addr_i   = addr;
        bus.uart_data_i     = data;
        bus.uart_w_enable_i = 1'b1;
        @(negedge clk);
        bus.uart_w_enable_i = 1'b0;
        $display("write addr=0x%08h data=0x%08h", addr, data);
    endtask

    // Starts driving immediately; callers are always on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (bit_cycles) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_cycles) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bit_cycles) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        $display("frame byte=0x%02h stop=%0b", b, stop_bit);
    endtask

    initial begin
        bus.uart_r_addr_i   = '0;
        bus.uart_w_addr_i   = '0;
        bus.uart_data_i     = '0;
        bus.uart_r_enable_i = 1'b0;
        bus.uart_w_enable_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_data_o", bus.uart_data_o, 32'h0);
        rd_chk("rst_status", A_STATUS, 32'h0);
        rd_chk("rst_baud", A_BAUD, 32'd87);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_data_empty", A_DATA, 32'h0);
        rd_chk("hole_addr", UART_RX_ADDR_START + 32'h2, 32'h0);
        rd_chk("out_of_range", UART_RX_ADDR_END + 32'h1, 32'h0);

        // Single good frame
        send_byte(8'hA5, 1'b1);
        rd_chk("a5_status", A_STATUS, 32'h11);
        rd_chk("a5_data", A_DATA, 32'hA5);
        rd_chk("a5_status_after", A_STATUS, 32'h00);

        // Overflow: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        rd_chk("ovf_status", A_STATUS, 32'h47);
        for (int i = 1; i <= 4; i++) rd_chk("ovf_data", A_DATA, 32'(i));
        rd_chk("ovf_fifth", A_DATA, 32'h0);
        rd_chk("ovf_sticky", A_STATUS, 32'h04);
        bus_write(A_STATUS, 32'h4);
        rd_chk("ovf_cleared", A_STATUS, 32'h00);

        // Frame error
        send_byte(8'h3C, 1'b0);
        rd_chk("ferr_status", A_STATUS, 32'h08);
        bus_write(A_STATUS, 32'h8);
        rd_chk("ferr_cleared", A_STATUS, 32'h00);

        // Pop on the very edge the fifth stop bit is sampled
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        rd_chk("full_status", A_STATUS, 32'h43);
        fork
            send_byte(8'h14, 1'b1);
            begin
                repeat (STOP_EDGE - 2) @(negedge clk);
                bus_read(A_DATA, d);
                chk("race_pop", d, 32'h10);
            end
        join
        rd_chk("race_status", A_STATUS, 32'h43);
        for (int i = 1; i <= 4; i++) rd_chk("race_order", A_DATA, 32'h10 + 32'(i));
        rd_chk("race_empty", A_STATUS, 32'h00);

        // Interrupt rise after the stop sample, fall after the emptying pop
        bus_write(A_CTRL, 32'h1);
        rd_chk("ctrl_rb", A_CTRL, 32'h1);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                chk("irq_before_stop", {31'b0, irq}, 32'h0);
                @(negedge clk);
                chk("irq_after_stop", {31'b0, irq}, 32'h1);
            end
        join
        @(negedge clk);
        bus.uart_r_addr_i   = A_DATA;
        bus.uart_r_enable_i = 1'b1;
        chk("irq_before_pop", {31'b0, irq}, 32'h1);
        @(negedge clk);
        bus.uart_r_enable_i = 1'b0;
        $display("read  addr=0x%08h data=0x%08h", A_DATA, bus.uart_data_o);
        chk("irq_data", bus.uart_data_o, 32'h7E);
        chk("irq_after_pop", {31'b0, irq}, 32'h0);

        // Glitch on idle line
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        $display("glitch low for 20 cycles");
        rd_chk("glitch_status", A_STATUS, 32'h00);
        chk("glitch_irq", {31'b0, irq}, 32'h0);
        send_byte(8'h5A, 1'b1);
        rd_chk("post_glitch_data", A_DATA, 32'h5A);

        // BAUD write during a frame only applies from the next frame; small values clamp to 4
        fork
            send_byte(8'h96, 1'b1);
            begin
                repeat (200) @(negedge clk);
                bus_write(A_BAUD, 32'h2);
            end
        join
        rd_chk("inflight_data", A_DATA, 32'h96);
        bit_cycles = 4;
        send_byte(8'hC3, 1'b1);
        rd_chk("clamp_data", A_DATA, 32'hC3);
        bus_write(A_BAUD, 32'd87);
        bit_cycles = 87;

        // Reset in the middle of a frame, during a high data bit
        bus_write(A_CTRL, 32'h1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (6 * 87 + 40) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                $display("reset pulse mid-frame");
            end
        join
        rd_chk("midrst_status", A_STATUS, 32'h00);
        rd_chk("midrst_ctrl", A_CTRL, 32'h0);
        rd_chk("midrst_data", A_DATA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
